// File: rtl/mem_access_ctrl_if.sv
// Memory-port controller bundle: control FSM request side,
// unified-memory side and captured instruction/data registers.
interface mem_access_ctrl_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] instr;
    logic [31:0] mdr;
    logic        stall;
    logic        done;
    logic        bus_err;
    logic [1:0]  err_status;

    modport master (
        output addr, wdata, IorD, MemRead, MemWrite, IRWrite,
        output mem_rdata, mem_ready,
        input  mem_addr, mem_wdata, mem_re, mem_we,
        input  instr, mdr, stall, done, bus_err, err_status
    );

    modport slave (
        input  addr, wdata, IorD, MemRead, MemWrite, IRWrite,
        input  mem_rdata, mem_ready,
        output mem_addr, mem_wdata, mem_re, mem_we,
        output instr, mdr, stall, done, bus_err, err_status
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Multicycle memory-port controller behind the IorD mux: one word
// access with wait states, IR/MDR capture, misalign and timeout flags.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input logic           clk,
    input logic           reset,
    mem_access_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE,
        ERR
    } state_t;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             iord_q;
    logic             irw_q;
    logic             re_q;
    logic             we_q;
    logic [31:0]      instr_q;
    logic [31:0]      mdr_q;
    logic             stall_q;
    logic             done_q;
    logic             berr_q;
    logic [1:0]       err_q;

    logic req_any;
    logic req_ok;

    assign req_any = bus.MemRead | bus.MemWrite;
    assign req_ok  = (bus.MemRead ^ bus.MemWrite)
                   && (bus.addr[1:0] == 2'b00);

    // Strobes are gated by reset so they fall in the reset cycle itself.
    assign bus.mem_re     = re_q & ~reset;
    assign bus.mem_we     = we_q & ~reset;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.instr      = instr_q;
    assign bus.mdr        = mdr_q;
    assign bus.stall      = stall_q;
    assign bus.done       = done_q;
    assign bus.bus_err    = berr_q;
    assign bus.err_status = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            iord_q  <= 1'b0;
            irw_q   <= 1'b0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            instr_q <= '0;
            mdr_q   <= '0;
            stall_q <= 1'b0;
            done_q  <= 1'b0;
            berr_q  <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            done_q <= 1'b0;
            berr_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_ok) begin
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        iord_q  <= bus.IorD;
                        irw_q   <= bus.IRWrite;
                        re_q    <= bus.MemRead;
                        we_q    <= bus.MemWrite;
                        cnt     <= '0;
                        stall_q <= 1'b1;
                        state   <= ACCESS;
                    end else if (req_any) begin
                        err_q[0] <= 1'b1;
                        berr_q   <= 1'b1;
                        state    <= ERR;
                    end
                end
                ACCESS: begin
                    // A ready on the final counted cycle still completes.
                    if (bus.mem_ready) begin
                        if (re_q && iord_q) begin
                            mdr_q <= bus.mem_rdata;
                        end else if (re_q && irw_q) begin
                            instr_q <= bus.mem_rdata;
                        end
                        re_q    <= 1'b0;
                        we_q    <= 1'b0;
                        stall_q <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end else if (cnt == TMO) begin
                        err_q[1] <= 1'b1;
                        re_q     <= 1'b0;
                        we_q     <= 1'b0;
                        stall_q  <= 1'b0;
                        berr_q   <= 1'b1;
                        state    <= ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed plus randomized checks of mem_access_ctrl against a
// transaction-level model of registers and sticky error bits.
module tb_mem_access_ctrl;

    localparam int TMO = 255;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    logic [31:0] m_instr;
    logic [31:0] m_mdr;
    logic [1:0]  m_err;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(
        .TIMEOUT_CYC(TMO),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IorD      = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.mem_ready = 1'b0;
    endtask

    // One request from IDLE; waits = no-ready ACCESS cycles before ready.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] wd,
                           input logic iord, input logic rd,
                           input logic wr, input logic irw,
                           input int waits, input logic [31:0] rdat);
        logic bad;
        logic tmo;
        int   nacc;
        bad = (rd && wr) || (a[1:0] != 2'b00);
        @(negedge clk);
        bus.addr     = a;
        bus.wdata    = wd;
        bus.IorD     = iord;
        bus.MemRead  = rd;
        bus.MemWrite = wr;
        bus.IRWrite  = irw;
        chk("idle_re", bus.mem_re, 0);
        chk("idle_we", bus.mem_we, 0);
        @(negedge clk);
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        if (bad) begin
            m_err[0] = 1'b1;
            chk("mis_berr", bus.bus_err, 1);
            chk("mis_stall", bus.stall, 0);
            chk("mis_re", bus.mem_re, 0);
            chk("mis_we", bus.mem_we, 0);
            chk("mis_done", bus.done, 0);
        end else begin
            tmo  = waits > TMO;
            nacc = tmo ? TMO + 1 : waits + 1;
            for (int k = 0; k < nacc; k++) begin
                chk("acc_stall", bus.stall, 1);
                chk("acc_re", bus.mem_re, rd);
                chk("acc_we", bus.mem_we, wr);
                chk("acc_addr", bus.mem_addr, a);
                chk("acc_wdata", bus.mem_wdata, wd);
                chk("acc_done", bus.done, 0);
                bus.mem_ready = (k == waits);
                bus.mem_rdata = (k == waits) ? rdat : $urandom;
                @(negedge clk);
            end
            bus.mem_ready = 1'b0;
            if (tmo) begin
                m_err[1] = 1'b1;
                chk("tmo_berr", bus.bus_err, 1);
                chk("tmo_done", bus.done, 0);
            end else begin
                if (rd && iord) m_mdr = rdat;
                else if (rd && irw) m_instr = rdat;
                chk("end_done", bus.done, 1);
                chk("end_berr", bus.bus_err, 0);
            end
            chk("end_stall", bus.stall, 0);
            chk("end_re", bus.mem_re, 0);
            chk("end_we", bus.mem_we, 0);
        end
        chk("instr", bus.instr, m_instr);
        chk("mdr", bus.mdr, m_mdr);
        chk("err_status", bus.err_status, m_err);
        @(negedge clk);
        chk("post_done", bus.done, 0);
        chk("post_berr", bus.bus_err, 0);
        chk("post_stall", bus.stall, 0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_instr = '0;
        m_mdr   = '0;
        m_err   = 2'b00;
        reset   = 1'b1;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.mem_rdata = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_instr", bus.instr, 0);
        chk("rst_mdr", bus.mdr, 0);
        chk("rst_maddr", bus.mem_addr, 0);
        chk("rst_mwdata", bus.mem_wdata, 0);
        chk("rst_re", bus.mem_re, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_berr", bus.bus_err, 0);
        chk("rst_err", bus.err_status, 0);

        // fetch, load, store, misaligned
        run_txn(32'h0000_0040, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1,
                2, 32'h8C22_0004);
        chk("fetch_instr", bus.instr, 32'h8C22_0004);
        run_txn(32'h0000_1004, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0,
                0, 32'hDEAD_BEEF);
        chk("load_mdr", bus.mdr, 32'hDEAD_BEEF);
        run_txn(32'h0000_2000, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 1'b0,
                3, 32'hFFFF_FFFF);
        run_txn(32'h0000_0080, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0,
                1, 32'h5555_AAAA);
        run_txn(32'h0000_1002, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0,
                0, 32'h0);
        chk("mis_err01", bus.err_status, 2'b01);
        run_txn(32'h0000_1000, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0,
                0, 32'h0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic        rd;
            logic        wr;
            int          r;
            r  = $urandom_range(0, 9);
            a  = $urandom;
            a[1:0] = (r == 1) ? 2'($urandom_range(1, 3)) : 2'b00;
            rd = 1'($urandom);
            wr = (r == 0) ? 1'b1 : ~rd;
            if (r == 0) rd = 1'b1;
            run_txn(a, $urandom, 1'($urandom), rd, wr, 1'($urandom),
                    $urandom_range(0, 5), $urandom);
        end

        // ready on the last counted cycle, then a true timeout
        run_txn(32'h0000_3000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0,
                TMO, 32'hCAFE_F00D);
        chk("edge_mdr", bus.mdr, 32'hCAFE_F00D);
        run_txn(32'h0000_3004, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0,
                TMO + 1, 32'h0);
        chk("tmo_err_bit", bus.err_status[1], 1);

        // reset while in ACCESS, with a ready that must not capture
        @(negedge clk);
        bus.addr    = 32'h0000_4000;
        bus.IorD    = 1'b1;
        bus.MemRead = 1'b1;
        @(negedge clk);
        bus.MemRead = 1'b0;
        chk("rsta_re", bus.mem_re, 1);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0BAD_0BAD;
        reset = 1'b1;
        #1;
        chk("rsta_re_drop", bus.mem_re, 0);
        @(negedge clk);
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        m_instr = '0;
        m_mdr   = '0;
        m_err   = 2'b00;
        chk("rsta_mdr", bus.mdr, m_mdr);
        chk("rsta_instr", bus.instr, m_instr);
        chk("rsta_err", bus.err_status, m_err);
        chk("rsta_stall", bus.stall, 0);
        chk("rsta_done", bus.done, 0);
        chk("rsta_addr", bus.mem_addr, 0);
        run_txn(32'h0000_0044, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1,
                0, 32'h2002_0001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
